// File: rtl/wb_bus_if_pkg.sv
// Shared encodings and bus widths for the CPU-side Wishbone classic master.
package wb_bus_if_pkg;

  localparam int WB_ADDR_W      = 32;
  localparam int WB_DATA_W      = 32;
  localparam int WB_TIMEOUT_CYC = 255;

  localparam logic [WB_DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    STATE_IDLE           = 2'd0,
    STATE_BUSY           = 2'd1,
    STATE_WAIT_FOR_STALL = 2'd2
  } wb_state_e;

  // Width of the timeout counter; stays at least one bit when the timeout is disabled.
  function automatic int cnt_width(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_bus_if.sv
// Wishbone B4 classic master: turns a single-cycle CPU request into a bus cycle,
// stalls the pipeline until ack and holds read data while other stages stall.
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W,
  parameter int TIMEOUT_CYC = WB_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  input  logic [DATA_W-1:0]   wishbone_data_i,
  input  logic                wishbone_ack_i,
  output logic [ADDR_W-1:0]   wishbone_addr_o,
  output logic [DATA_W-1:0]   wishbone_data_o,
  output logic                wishbone_we_o,
  output logic [DATA_W/8-1:0] wishbone_sel_o,
  output logic                wishbone_stb_o,
  output logic                wishbone_cyc_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

  wb_state_e          state_r, state_nxt_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               we_r;
  logic [SEL_W-1:0]   sel_r;
  logic               stb_r;
  logic [DATA_W-1:0]  rbuf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               bus_err_r;

  logic               start_s;
  logic               release_s;
  logic               latch_s;
  logic               timeout_s;
  logic               buf_clr_s;
  logic               stallreq_s;
  logic [DATA_W-1:0]  cpu_data_s;

  // Next-state decode and combinational CPU-side outputs.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    release_s   = 1'b0;
    latch_s     = 1'b0;
    timeout_s   = 1'b0;
    buf_clr_s   = 1'b0;
    stallreq_s  = 1'b0;
    cpu_data_s  = {DATA_W{1'b0}};
    case (state_r)
      STATE_IDLE: begin
        stallreq_s = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          start_s     = 1'b1;
          buf_clr_s   = 1'b1;
          state_nxt_s = STATE_BUSY;
        end else begin
          state_nxt_s = STATE_IDLE;
        end
      end
      STATE_BUSY: begin
        // Flush beats ack, and an ack in the last allowed cycle beats the timeout.
        if (flush_i) begin
          release_s   = 1'b1;
          buf_clr_s   = 1'b1;
          state_nxt_s = STATE_IDLE;
        end else if (wishbone_ack_i) begin
          release_s   = 1'b1;
          latch_s     = ~we_r;
          cpu_data_s  = we_r ? {DATA_W{1'b0}} : wishbone_data_i;
          state_nxt_s = (stall_i != 6'b000000) ? STATE_WAIT_FOR_STALL : STATE_IDLE;
        end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
          release_s   = 1'b1;
          timeout_s   = 1'b1;
          buf_clr_s   = 1'b1;
          state_nxt_s = STATE_IDLE;
        end else begin
          stallreq_s  = 1'b1;
          state_nxt_s = STATE_BUSY;
        end
      end
      STATE_WAIT_FOR_STALL: begin
        cpu_data_s = rbuf_r;
        if (flush_i) begin
          buf_clr_s   = 1'b1;
          state_nxt_s = STATE_IDLE;
        end else if (stall_i == 6'b000000) begin
          state_nxt_s = STATE_IDLE;
        end else begin
          state_nxt_s = STATE_WAIT_FOR_STALL;
        end
      end
      default: begin
        state_nxt_s = STATE_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered Wishbone request; fields are held stable while stb is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      sel_r   <= {SEL_W{1'b0}};
    end else if (start_s) begin
      stb_r   <= 1'b1;
      addr_r  <= cpu_addr_i;
      wdata_r <= cpu_data_i;
      we_r    <= cpu_we_i;
      sel_r   <= cpu_sel_i;
    end else if (release_s) begin
      stb_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      sel_r   <= {SEL_W{1'b0}};
    end
  end

  // Read buffer, saturating timeout counter and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbuf_r    <= ZERO_WORD[DATA_W-1:0];
      cnt_r     <= {CNT_W{1'b0}};
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= timeout_s;
      if (buf_clr_s) begin
        rbuf_r <= {DATA_W{1'b0}};
      end else if (latch_s) begin
        rbuf_r <= wishbone_data_i;
      end
      if (start_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == STATE_BUSY) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign wishbone_stb_o  = stb_r;
  assign wishbone_cyc_o  = stb_r;
  assign wishbone_addr_o = addr_r;
  assign wishbone_data_o = wdata_r;
  assign wishbone_we_o   = we_r;
  assign wishbone_sel_o  = sel_r;
  assign bus_err_o       = bus_err_r;
  assign stallreq_o      = stallreq_s;
  assign cpu_data_o      = cpu_data_s;

endmodule

// File: tb/tb_wb_bus_if.sv
// Randomised scoreboard bench for wb_bus_if: the driver pushes per-transaction
// expectations, a negedge monitor measures each bus episode and compares.
module tb_wb_bus_if;

  localparam int TO       = 4;
  localparam int K_DONE   = 0;
  localparam int K_FLUSH  = 1;
  localparam int K_TO     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = 6'd0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'd0;
  logic [31:0] cpu_data_i = 32'd0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = 4'd0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wishbone_data_i = 32'd0;
  logic        wishbone_ack_i = 1'b0;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  wb_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          n_sr;
    int          n_stb;
    int          n_err;
    int          n_hold;
    logic        got_ack;
    logic [31:0] ack_data;
    logic [31:0] end_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One CPU access: build the expected outcome from the protocol rules, then drive it.
  task automatic do_txn(input int kind, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input logic [31:0] rdata, input int w, input int f,
                        input int k, input logic [5:0] stall_val);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel;
    e.n_err = 0; e.n_hold = 0; e.got_ack = 1'b0;
    e.ack_data = 32'd0; e.end_data = 32'd0;
    if (kind == K_DONE) begin
      e.n_sr = 1 + w; e.n_stb = 1 + w; e.n_hold = k; e.got_ack = 1'b1;
      e.ack_data = we ? 32'd0 : rdata;
      e.end_data = (!we && k > 0) ? rdata : 32'd0;
    end else if (kind == K_FLUSH) begin
      e.n_sr = 1 + f; e.n_stb = 1 + f;
    end else begin
      e.n_sr = TO; e.n_stb = TO; e.n_err = 1;
    end
    exp_q.push_back(e);

    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata; cpu_sel_i = sel;
    stall_i = 6'd0; flush_i = 1'b0; wishbone_ack_i = 1'b0;
    adv();
    cpu_ce_i = 1'b0; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom;
    cpu_data_i = $urandom; cpu_sel_i = 4'($urandom);
    if (kind == K_DONE) begin
      for (int j = 0; j < w; j++) begin wishbone_data_i = $urandom; adv(); end
      wishbone_ack_i = 1'b1; wishbone_data_i = rdata;
      stall_i = (k > 0) ? stall_val : 6'd0;
      adv();
      wishbone_ack_i = 1'b0; wishbone_data_i = $urandom;
      for (int i = 0; i < k; i++) begin stall_i = stall_val; adv(); end
      stall_i = 6'd0;
      adv();
    end else if (kind == K_FLUSH) begin
      for (int j = 0; j < f; j++) adv();
      flush_i = 1'b1;
      adv();
      flush_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1234_5678;
      adv();
      wishbone_ack_i = 1'b0;
    end else begin
      for (int j = 0; j < TO; j++) adv();
      adv();
    end
  endtask

  // Monitor: measure each access episode on the falling edge and score it.
  initial begin
    bit          active = 1'b0;
    bit          unstable = 1'b0;
    int          n_sr = 0, n_stb = 0, n_err = 0, n_hold = 0, hold_bad = 0;
    logic        got_ack = 1'b0;
    logic [31:0] ack_data = 32'd0, c_addr = 32'd0, c_wdata = 32'd0;
    logic        c_we = 1'b0;
    logic [3:0]  c_sel = 4'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
      end else begin
        if (!active && stallreq_o) begin
          active = 1'b1; unstable = 1'b0; got_ack = 1'b0; ack_data = 32'd0;
          n_sr = 0; n_stb = 0; n_err = 0; n_hold = 0; hold_bad = 0;
        end
        if (active) begin
          if (stallreq_o) n_sr++;
          if (bus_err_o) n_err++;
          if (wishbone_stb_o !== wishbone_cyc_o) unstable = 1'b1;
          if (wishbone_stb_o) begin
            if (n_stb == 0) begin
              c_addr = wishbone_addr_o; c_wdata = wishbone_data_o;
              c_we = wishbone_we_o; c_sel = wishbone_sel_o;
            end else if (c_addr !== wishbone_addr_o || c_wdata !== wishbone_data_o ||
                         c_we !== wishbone_we_o || c_sel !== wishbone_sel_o) begin
              unstable = 1'b1;
            end
            n_stb++;
            if (wishbone_ack_i && !flush_i) begin got_ack = 1'b1; ack_data = cpu_data_o; end
          end else if (n_stb > 0) begin
            if (stall_i != 6'd0) begin
              n_hold++;
              if (exp_q.size() > 0 && cpu_data_o !== exp_q[0].end_data) hold_bad++;
            end else begin
              active = 1'b0;
              if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 64'(1), 64'(0));
              end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 64'(c_addr), 64'(e.addr));
                chk("wb_we", 64'(c_we), 64'(e.we));
                chk("wb_sel", 64'(c_sel), 64'(e.sel));
                if (e.we) chk("wb_wdata", 64'(c_wdata), 64'(e.wdata));
                chk("bus_stable", 64'(unstable), 64'(0));
                chk("stb_cycles", 64'(n_stb), 64'(e.n_stb));
                chk("stallreq_cycles", 64'(n_sr), 64'(e.n_sr));
                chk("bus_err_pulses", 64'(n_err), 64'(e.n_err));
                chk("ack_taken", 64'(got_ack), 64'(e.got_ack));
                if (e.got_ack) chk("ack_cpu_data", 64'(ack_data), 64'(e.ack_data));
                chk("hold_cycles", 64'(n_hold), 64'(e.n_hold));
                chk("hold_cpu_data", 64'(hold_bad), 64'(0));
                chk("end_cpu_data", 64'(cpu_data_o), 64'(e.end_data));
              end
            end
          end
        end
      end
    end
  end

  // Driver: reset checks, directed scenarios, then random accesses.
  initial begin
    int r, kind;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stb", 64'(wishbone_stb_o), 64'(0));
    chk("rst_cyc", 64'(wishbone_cyc_o), 64'(0));
    chk("rst_addr", 64'(wishbone_addr_o), 64'(0));
    chk("rst_wdata", 64'(wishbone_data_o), 64'(0));
    chk("rst_we_sel", 64'({wishbone_we_o, wishbone_sel_o}), 64'(0));
    chk("rst_bus_err", 64'(bus_err_o), 64'(0));
    chk("rst_stallreq", 64'(stallreq_o), 64'(0));
    chk("rst_cpu_data", 64'(cpu_data_o), 64'(0));
    #3 rst = 1'b1;
    adv();

    do_txn(K_DONE, 1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h3401_1100, 0, 0, 0, 6'd0);
    do_txn(K_DONE, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 3, 0, 0, 6'd0);
    do_txn(K_DONE, 1'b0, 32'h0000_0008, 32'd0, 4'hF, 32'hA5A5_A5A5, 1, 0, 3, 6'b000111);
    do_txn(K_FLUSH, 1'b0, 32'h0000_000C, 32'd0, 4'hF, 32'd0, 0, 1, 0, 6'd0);
    do_txn(K_TO, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'd0, 0, 0, 0, 6'd0);
    do_txn(K_DONE, 1'b0, 32'h0000_0014, 32'd0, 4'h3, 32'hCAFE_0001, 0, 0, 0, 6'd0);

    // Asynchronous reset in the middle of a bus cycle.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0020; cpu_sel_i = 4'hF;
    adv();
    cpu_ce_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_stb", 64'(wishbone_stb_o), 64'(0));
    chk("arst_cyc", 64'(wishbone_cyc_o), 64'(0));
    chk("arst_addr", 64'(wishbone_addr_o), 64'(0));
    chk("arst_sel_we", 64'({wishbone_we_o, wishbone_sel_o}), 64'(0));
    chk("arst_stallreq", 64'(stallreq_o), 64'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    adv();
    do_txn(K_DONE, 1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h3401_1100, 0, 0, 0, 6'd0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_DONE : ((r < 8) ? K_FLUSH : K_TO);
      do_txn(kind, 1'($urandom), $urandom, $urandom, 4'($urandom_range(1, 15)),
             $urandom, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
             $urandom_range(0, 3), 6'($urandom_range(1, 63)));
      repeat ($urandom_range(0, 2)) adv();
    end

    repeat (3) adv();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_bus_if.md
Name: wb_bus_if

Overview:
- Wishbone B4 classic master that sits between the open_mips_top core's instruction-fetch or data-memory port and the SoC bus.
- Replaces the direct inst_rom hookup so the ROM, and later the RAM, can be slaves with variable latency.
- Converts a single-cycle CPU request (ce/addr/we/sel/data) into a Wishbone cycle.
- Holds the pipeline via stallreq_o until ack arrives, and buffers read data while the pipeline is still stalled by other stages.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width (sel width = DATA_W/8)
- TIMEOUT_CYC, 255, cycles in BUSY without ack before the cycle is aborted; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- stall_i  in  6  pipeline stall vector from ctrl
- flush_i  in  1  pipeline flush (exception)
- cpu_ce_i  in  1  CPU request valid
- cpu_addr_i  in  ADDR_W  request address
- cpu_data_i  in  DATA_W  write data
- cpu_we_i  in  1  1 = write
- cpu_sel_i  in  DATA_W/8  byte enables
- cpu_data_o  out  DATA_W  read data to CPU
- stallreq_o  out  1  stall request to ctrl
- bus_err_o  out  1  one-cycle pulse on timeout abort
- wishbone_data_i  in  DATA_W  slave read data
- wishbone_ack_i  in  1  slave ack
- wishbone_addr_o  out  ADDR_W
- wishbone_data_o  out  DATA_W
- wishbone_we_o  out  1
- wishbone_sel_o  out  DATA_W/8
- wishbone_stb_o  out  1
- wishbone_cyc_o  out  1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all wishbone_*_o=0; read buffer=0; timeout counter=0; bus_err_o=0.
  - Comb outputs stallreq_o and cpu_data_o evaluate to 0 in IDLE with no request.
- States: IDLE, BUSY, WAIT_FOR_STALL. All wishbone_*_o are registered.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0:
    - Register stb=cyc=1; addr, data, we and sel from cpu_*_i.
    - Clear buffer and counter; next state BUSY.
  - Comb: stallreq_o=cpu_ce_i & ~flush_i; cpu_data_o=0.
- BUSY, wishbone_ack_i=1:
  - Register stb=cyc=we=0; addr=data=sel=0.
  - If we=0, latch buffer<=wishbone_data_i.
  - Next state WAIT_FOR_STALL if stall_i!=0, else IDLE.
  - Comb (same cycle): stallreq_o=0; cpu_data_o=wishbone_data_i for a read, 0 for a write.
- BUSY, no ack:
  - Comb: stallreq_o=1; cpu_data_o=0; counter increments.
- BUSY, flush_i=1 (priority over ack): drop stb/cyc, discard data, clear buffer, next IDLE; stallreq_o=0 that cycle.
- BUSY, timeout (TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC-1 with no ack):
  - Drop stb/cyc; pulse bus_err_o for 1 cycle; buffer=0; next IDLE.
  - stallreq_o=0 that cycle; cpu_data_o=0.
- WAIT_FOR_STALL:
  - Comb: stallreq_o=0; cpu_data_o=buffer.
  - Next IDLE when stall_i==0; any flush_i → IDLE with buffer cleared.
  - No new request is issued here, so the same instruction is never fetched twice.
- Latency:
  - Request seen in cycle N → stb/cyc high from N+1.
  - Zero-wait slave acks at N+1 → data on cpu_data_o in N+1; minimum 2 cycles per access.
- Wishbone rule: stb and cyc are always equal. Address/data/sel/we are stable while stb=1. An ack while in IDLE/WAIT_FOR_STALL is ignored.
- Reset mid-cycle: bus released immediately (async); no residual pulse.
- Counter width = clog2(TIMEOUT_CYC+1); saturates, never wraps.

Decomposition:
- STATE_IDLE/BUSY/WAIT_FOR_STALL encodings, WB_ADDR_W, WB_DATA_W and ZeroWord go in defines.v alongside the existing InstAddrBus/InstBus/RegBus.
- No sub-module; a single FSM plus one counter is natural.
- mini_sopc later instantiates two copies (iwishbone, dwishbone).

Test Plan:
- Zero-wait read: ce=1, addr=0x00000004, slave acks the next cycle with 0x34011100 → stb/cyc high exactly 1 cycle; cpu_data_o=0x34011100 in the ack cycle; stallreq_o high 1 cycle; back to IDLE.
- 3-wait write: we=1, sel=0xF, data=0xDEADBEEF, ack on the 4th cycle → addr/data stable for all 4 cycles; stallreq_o=1 for 4 cycles then 0; cpu_data_o=0.
- Stalled completion: read acks with 0xA5A5A5A5 while stall_i=6'b000111 for 3 more cycles → WAIT_FOR_STALL; cpu_data_o holds 0xA5A5A5A5; no new stb; returns to IDLE when stall_i=0.
- Flush mid-BUSY: flush_i=1 on cycle 2 of an un-acked read → stb/cyc=0 next cycle; a late ack with 0x12345678 is ignored; cpu_data_o stays 0.
- Timeout: TIMEOUT_CYC=4, slave never acks → stb high 4 cycles; bus_err_o pulses once; state IDLE; a new request is accepted afterwards.
- Async reset: assert rst=0 mid-BUSY between clock edges → all wishbone outputs 0 immediately; after release, the first request behaves as in the zero-wait read scenario.
